// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM duty as active cycles per free-running 2^WIDTH-clock window,
// reporting a saturated WIDTH-bit level with a one-cycle strobe, stuck and changed flags.
module pwm_capture #(
    parameter int WIDTH       = 8,
    parameter bit INVERT      = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic             level_valid,
    output logic             stuck,
    output logic             changed
);
    localparam logic [WIDTH-1:0] LAST = '1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s, prev, edge_now, edge_seen, last;
    logic [WIDTH-1:0]       wcnt, sat;
    logic [WIDTH:0]         hcnt, total;

    assign s        = sync[SYNC_STAGES-1] ^ INVERT;
    assign edge_now = s != prev;
    assign last     = wcnt == LAST;
    assign total    = hcnt + {{WIDTH{1'b0}}, s};
    // a window active on every cycle counts 2^WIDTH, which clips to all-ones
    assign sat      = total[WIDTH] ? LAST : total[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync        <= '0;
            prev        <= 1'b0;
            wcnt        <= '0;
            hcnt        <= '0;
            edge_seen   <= 1'b0;
            level       <= '0;
            level_valid <= 1'b0;
            stuck       <= 1'b0;
            changed     <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], pwm_in};
            prev        <= s;
            wcnt        <= wcnt + 1'b1;
            hcnt        <= last ? '0 : total;
            edge_seen   <= last ? 1'b0 : edge_seen | edge_now;
            level_valid <= last;
            changed     <= last && sat != level;
            if (last) begin
                level <= sat;
                stuck <= !(edge_seen | edge_now);
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: two instances (non-inverted/2-stage and inverted/3-stage) share one PWM input,
// each compared every cycle against a window-sum model of the sampled input history.
module tb_pwm_capture;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       pwm_in;
    logic [3:0] lv [2];
    logic       vl [2];
    logic       st [2];
    logic       ch [2];

    int checks   = 0;
    int failures = 0;
    bit hist[$];
    int mlvl[2];
    int mstk[2];

    pwm_capture #(.WIDTH(4), .INVERT(1'b0), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
        .level(lv[0]), .level_valid(vl[0]), .stuck(st[0]), .changed(ch[0])
    );
    pwm_capture #(.WIDTH(4), .INVERT(1'b1), .SYNC_STAGES(3)) dut_inv (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
        .level(lv[1]), .level_valid(vl[1]), .stuck(st[1]), .changed(ch[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // value the counter sees at edge k: input from SYNC_STAGES edges earlier, zero while filling
    function automatic bit s_at(input int k, input int d);
        int sg = d ? 3 : 2;
        return (k < sg ? 1'b0 : hist[k-sg]) ^ d[0];
    endfunction

    task automatic step(input bit v);
        int n;
        pwm_in = v;
        hist.push_back(v);
        n = hist.size() - 1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit w;
            int c, tot, sat;
            bit e;
            w = (n % 16) == 15;
            c = 0;
            if (w) begin
                tot = 0;
                e = 1'b0;
                for (int k = n - 15; k <= n; k++) begin
                    tot += int'(s_at(k, d));
                    e |= s_at(k, d) != (k == 0 ? 1'b0 : s_at(k - 1, d));
                end
                sat = tot > 15 ? 15 : tot;
                c = int'(sat != mlvl[d]);
                mlvl[d] = sat;
                mstk[d] = int'(!e);
            end
            check($sformatf("valid[%0d] n=%0d", d, n), int'(vl[d]), int'(w));
            check($sformatf("level[%0d] n=%0d", d, n), int'(lv[d]), mlvl[d]);
            check($sformatf("stuck[%0d] n=%0d", d, n), int'(st[d]), mstk[d]);
            check($sformatf("changed[%0d] n=%0d", d, n), int'(ch[d]), c);
        end
        @(negedge clk);
    endtask

    function automatic bit gen(input int lvl, input int ph);
        return ((hist.size() + ph) % 16) < lvl;
    endfunction

    task automatic run(input int lvl, input int ph, input int cycles);
        for (int i = 0; i < cycles; i++) step(gen(lvl, ph));
    endtask

    task automatic seg(input int lvl, input int ph, input int windows);
        while (hist.size() % 16 != 0) step(gen(lvl, ph));
        run(lvl, ph, windows * 16);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_level[%0d]", d), int'(lv[d]), 0);
            check($sformatf("rst_valid[%0d]", d), int'(vl[d]), 0);
            check($sformatf("rst_stuck[%0d]", d), int'(st[d]), 0);
            check($sformatf("rst_changed[%0d]", d), int'(ch[d]), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        hist.delete();
        mlvl = '{0, 0};
        mstk = '{0, 0};
    endtask

    task automatic expect_now(input string tag, input int l0, input int l1, input int s);
        check({tag, "_lvl"}, int'(lv[0]), l0);
        check({tag, "_inv"}, int'(lv[1]), l1);
        check({tag, "_stuck"}, int'(st[0]), s);
    endtask

    initial begin
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        @(negedge clk);
        do_reset();
        seg(5, 0, 3);
        expect_now("gen5", 5, 11, 0);
        seg(0, 0, 3);
        expect_now("low", 0, 15, 1);
        seg(16, 0, 3);
        expect_now("high", 15, 0, 1);
        seg(3, 4, 2);
        run(3, 4, 8);
        seg(12, 4, 2);
        expect_now("switch12", 12, 4, 0);
        while (hist.size() % 16 != 9) step(gen(5, 0));
        do_reset();
        seg(5, 0, 2);
        expect_now("after_rst", 5, 11, 0);
        for (int p = 0; p < 16; p++) begin
            seg(7, p, 3);
            expect_now($sformatf("phase%0d", p), 7, 9, 0);
        end
        repeat (20) begin
            seg(int'($urandom_range(0, 16)), int'($urandom_range(0, 15)), 2);
            if ($urandom_range(0, 3) == 0) begin
                run(int'($urandom_range(0, 16)), 0, int'($urandom_range(1, 15)));
                do_reset();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
